floo_look_ahead_route_stage: RTL
================================

Name: floo_look_ahead_route_stage

Overview:
- Registered, multi-port look-ahead routing stage for the VC router input side.
- For each of NumInputs input ports, it computes the output direction the flit will take at the *next* router (XY dimension-ordered).
- The computation uses this router's coordinate and the current-hop direction already carried in the header.
- Head flits compute and lock the next-hop direction; body/tail flits reuse the locked value until the last flit. Each port is an independent one-deep valid/ready pipeline register.

Parameters:
- NumInputs, 5, number of independent input ports/lanes.
- XWidth, 4, width of X coordinate fields.
- YWidth, 4, width of Y coordinate fields.
- DirWidth, 3, width of direction encoding (North=0, East=1, South=2, West=3, Eject=4; 5..7 illegal).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- xy_x_i  in  XWidth  this router's X coordinate (quasi-static)
- xy_y_i  in  YWidth  this router's Y coordinate (quasi-static)
- valid_i  in  NumInputs  per-port flit valid
- ready_o  out  NumInputs  per-port ready
- dst_x_i  in  NumInputs*XWidth  destination X per port
- dst_y_i  in  NumInputs*YWidth  destination Y per port
- dir_i  in  NumInputs*DirWidth  direction this router uses (precomputed upstream)
- last_i  in  NumInputs  flit is last of packet
- valid_o  out  NumInputs  per-port output valid
- ready_i  in  NumInputs  per-port downstream ready
- dir_o  out  NumInputs*DirWidth  registered copy of dir_i
- nxt_dir_o  out  NumInputs*DirWidth  direction to be used at next router
- last_o  out  NumInputs  registered copy of last_i
- err_o  out  NumInputs  sticky per-port boundary/encoding error

Behaviour:
- Reset: valid_o=0, dir_o=0, nxt_dir_o=0, last_o=0, err_o=0. All ports are in HEAD state with the lock register at 0.
- Handshake per port p:
  - ready_o[p] = !valid_q[p] || ready_i[p], which is combinational from ready_i.
  - Transfer in = valid_i[p] && ready_o[p]; transfer out = valid_o[p] && ready_i[p].
  - Simultaneous in and out in the same cycle: the register reloads and valid stays 1, so full throughput is 1 flit/cycle.
  - Latency is exactly 1 cycle from accepted input to valid_o.
- Outputs are stable while valid_o[p]=1 and ready_i[p]=0.
- Next coordinate (nx, ny) from dir_i:
  - North: ny = y+1. South: ny = y-1. East: nx = x+1. West: nx = x-1.
  - Eject: unchanged.
  - Arithmetic is modulo 2^Width.
- Next direction at (nx, ny):
  - dst_x > nx → East; dst_x < nx → West.
  - Otherwise dst_y > ny → North; dst_y < ny → South.
  - Otherwise Eject.
  - If dir_i == Eject, nxt_dir = Eject. Comparisons are unsigned.
- Per-port FSM:
  - HEAD: on transfer in, compute nxt_dir, register it into both the output and the lock register. If last_i=0, go to BODY; else stay in HEAD (single-flit packet).
  - BODY: on transfer in, nxt_dir_o ← lock register (no recompute). If last_i=1, return to HEAD.
  - No transfer: state holds.
- Reset mid-packet: the FSM returns to HEAD and the in-flight register is discarded (valid_o=0).
- Ports are fully independent; no cross-port arbitration or interaction.

Optional Feature:
- Macro: FLOO_LAH_ROUTE_ERR_CHECK_EN
- Defined: on a HEAD transfer, err_o[p] is set (sticky until reset) if any of the following holds:
  - dir_i is in 5..7;
  - the North/East increment overflows (coordinate at all-ones);
  - the South/West decrement underflows (coordinate at 0).
  - On error, nxt_dir_o is forced to Eject for that packet.
- Not defined: err_o is tied 0, arithmetic wraps silently, and illegal dir_i yields nxt_dir = Eject.

Test Plan:
- Basic hop: xy=(1,1), dst=(3,1), dir_i=East, last=1 → next cycle valid_o=1, dir_o=East(1), nxt_dir_o=East(1).
- Turn at next router: xy=(2,1), dst=(3,3), dir_i=East → nxt_dir_o=North(0). With dst=(3,0) → South(2).
- Lock: head dst=(0,0), dir_i=West at xy=(2,2) → nxt West(3). Then 3 body flits with dst fields corrupted to (7,7), last on the 4th → all four flits have nxt_dir_o=West. The following head recomputes.
- Backpressure: ready_i=0 for 5 cycles with a flit held → ready_o=0 and outputs stable. Then ready_i=1 with valid_i=1 every cycle → 1 flit/cycle, no loss or duplication, order preserved.
- Port independence: port 0 stalled, port 3 streams 10 flits → port 3 delivers all 10 in 10 cycles, port 0 unchanged.
- Error (macro defined): xy=(0,0), dir_i=West → err_o=1 and nxt_dir_o=Eject(4), err_o remains 1 after later legal packets. Reset → err_o=0.

Source files
------------

// File: rtl/floo_look_ahead_route_stage.sv
// floo_look_ahead_route_stage
// Registered look-ahead XY routing stage for the router input side. Every
// input port is an independent one-deep valid/ready register. Head flits
// compute the direction they will take at the next router and lock it;
// body/tail flits reuse the locked direction until the last flit.
// Optional feature macro: FLOO_LAH_ROUTE_ERR_CHECK_EN
//   defined   : head flits with an illegal direction or a coordinate that
//               would wrap raise a sticky per-port err_o and route to Eject.
//   undefined : err_o is tied low and coordinate arithmetic wraps silently.
module floo_look_ahead_route_stage #(
  parameter int unsigned NumInputs = 5,
  parameter int unsigned XWidth    = 4,
  parameter int unsigned YWidth    = 4,
  parameter int unsigned DirWidth  = 3
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [XWidth-1:0]             xy_x_i,
  input  logic [YWidth-1:0]             xy_y_i,
  input  logic [NumInputs-1:0]          valid_i,
  output logic [NumInputs-1:0]          ready_o,
  input  logic [NumInputs*XWidth-1:0]   dst_x_i,
  input  logic [NumInputs*YWidth-1:0]   dst_y_i,
  input  logic [NumInputs*DirWidth-1:0] dir_i,
  input  logic [NumInputs-1:0]          last_i,
  output logic [NumInputs-1:0]          valid_o,
  input  logic [NumInputs-1:0]          ready_i,
  output logic [NumInputs*DirWidth-1:0] dir_o,
  output logic [NumInputs*DirWidth-1:0] nxt_dir_o,
  output logic [NumInputs-1:0]          last_o,
  output logic [NumInputs-1:0]          err_o
);

  localparam logic [DirWidth-1:0] DirNorth = DirWidth'(0);
  localparam logic [DirWidth-1:0] DirEast  = DirWidth'(1);
  localparam logic [DirWidth-1:0] DirSouth = DirWidth'(2);
  localparam logic [DirWidth-1:0] DirWest  = DirWidth'(3);
  localparam logic [DirWidth-1:0] DirEject = DirWidth'(4);

  typedef enum logic {
    StHead = 1'b0,
    StBody = 1'b1
  } state_e;

  // XY dimension-ordered decision taken at the neighbour reached via dir.
  // Illegal or Eject directions resolve to Eject.
  function automatic logic [DirWidth-1:0] route_next(
    input logic [XWidth-1:0]   x,
    input logic [YWidth-1:0]   y,
    input logic [XWidth-1:0]   dx,
    input logic [YWidth-1:0]   dy,
    input logic [DirWidth-1:0] dir
  );
    logic [XWidth-1:0]   nx;
    logic [YWidth-1:0]   ny;
    logic [DirWidth-1:0] nd;
    nx = x;
    ny = y;
    nd = DirEject;
    case (dir)
      DirNorth: ny = y + YWidth'(1);
      DirSouth: ny = y - YWidth'(1);
      DirEast:  nx = x + XWidth'(1);
      DirWest:  nx = x - XWidth'(1);
      default:  ;
    endcase
    if (dir <= DirWest) begin
      if (dx > nx)      nd = DirEast;
      else if (dx < nx) nd = DirWest;
      else if (dy > ny) nd = DirNorth;
      else if (dy < ny) nd = DirSouth;
      else              nd = DirEject;
    end
    return nd;
  endfunction

`ifdef FLOO_LAH_ROUTE_ERR_CHECK_EN
  // Flags illegal encodings and hops that would leave the coordinate range.
  function automatic logic route_err(
    input logic [XWidth-1:0]   x,
    input logic [YWidth-1:0]   y,
    input logic [DirWidth-1:0] dir
  );
    logic err;
    case (dir)
      DirNorth: err = &y;
      DirSouth: err = ~|y;
      DirEast:  err = &x;
      DirWest:  err = ~|x;
      DirEject: err = 1'b0;
      default:  err = 1'b1;
    endcase
    return err;
  endfunction
`endif

  for (genvar p = 0; p < NumInputs; p++) begin : g_port
    state_e              state_q, state_d;
    logic [DirWidth-1:0] lock_q;
    logic [DirWidth-1:0] head_nxt;
    logic [DirWidth-1:0] nxt_sel;
    logic                vld_p1;
    logic [DirWidth-1:0] dir_p1;
    logic [DirWidth-1:0] nxt_p1;
    logic                last_p1;
    logic                xfer_in;
    logic                err_head;

    assign ready_o[p] = !vld_p1 || ready_i[p];
    assign xfer_in    = valid_i[p] && ready_o[p];

`ifdef FLOO_LAH_ROUTE_ERR_CHECK_EN
    assign err_head = route_err(xy_x_i, xy_y_i, dir_i[p*DirWidth +: DirWidth]);
    assign head_nxt = err_head ? DirEject
                    : route_next(xy_x_i, xy_y_i,
                                 dst_x_i[p*XWidth +: XWidth],
                                 dst_y_i[p*YWidth +: YWidth],
                                 dir_i[p*DirWidth +: DirWidth]);
`else
    assign err_head = 1'b0;
    assign head_nxt = route_next(xy_x_i, xy_y_i,
                                 dst_x_i[p*XWidth +: XWidth],
                                 dst_y_i[p*YWidth +: YWidth],
                                 dir_i[p*DirWidth +: DirWidth]);
`endif

    // Packet framing: pick fresh or locked direction and advance on transfers.
    always_comb begin
      state_d = state_q;
      nxt_sel = lock_q;
      if (state_q == StHead) nxt_sel = head_nxt;
      if (xfer_in) begin
        if (state_q == StHead) state_d = last_i[p] ? StHead : StBody;
        else if (last_i[p])    state_d = StHead;
      end
    end

    // Framing state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_q <= StHead;
      else         state_q <= state_d;
    end

    // Stage p1: one-deep output register plus head-direction lock.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        vld_p1  <= 1'b0;
        dir_p1  <= '0;
        nxt_p1  <= '0;
        last_p1 <= 1'b0;
        lock_q  <= '0;
      end else begin
        if (xfer_in) begin
          vld_p1  <= 1'b1;
          dir_p1  <= dir_i[p*DirWidth +: DirWidth];
          nxt_p1  <= nxt_sel;
          last_p1 <= last_i[p];
          if (state_q == StHead) lock_q <= head_nxt;
        end else if (ready_i[p]) begin
          vld_p1 <= 1'b0;
        end
      end
    end

`ifdef FLOO_LAH_ROUTE_ERR_CHECK_EN
    logic err_q;
    // Sticky error flag, set only by head flits.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)                                        err_q <= 1'b0;
      else if (xfer_in && (state_q == StHead) && err_head) err_q <= 1'b1;
    end
    assign err_o[p] = err_q;
`else
    assign err_o[p] = err_head;
`endif

    assign valid_o[p]                      = vld_p1;
    assign dir_o[p*DirWidth +: DirWidth]   = dir_p1;
    assign nxt_dir_o[p*DirWidth +: DirWidth] = nxt_p1;
    assign last_o[p]                       = last_p1;
  end

endmodule
